// File: rtl/sme_pkg.sv
// Shared types for the masked SME ALU sequencer: opcode enum, FSM states,
// the one-hot strobe bundle driven to the ALU, and the RNG word-count helper.
// Pure declarations; no logic, no latency, no flow control of its own.
package sme_pkg;

  // Masked ALU opcodes as issued by the core's SME issue stage.
  typedef enum logic [3:0] {
    SME_XOR,
    SME_AND,
    SME_OR,
    SME_ANDN,
    SME_ORN,
    SME_XNOR,
    SME_SLL,
    SME_SRL,
    SME_ROL,
    SME_ROR,
    SME_ADD,
    SME_SUB,
    SME_MASK,
    SME_UNMASK,
    SME_REMASK
  } sme_alu_op_t;

  // Sequencer states: one operation in flight at most.
  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_RNG,
    SEQ_EXEC,
    SEQ_RESP
  } sme_alu_seq_state_t;

  // One-hot (plus modifier) strobes presented to the masked ALU.
  typedef struct packed {
    logic op_xor;
    logic op_and;
    logic op_or;
    logic op_notrs2;
    logic op_shift;
    logic op_rotate;
    logic op_left;
    logic op_right;
    logic op_add;
    logic op_sub;
    logic op_mask;
    logic op_unmask;
    logic op_remask;
  } sme_alu_strb_t;

  // Number of RNG words needed for smax shares: one per share for refreshing
  // plus one per share pair for the masked multiply/and gadget.
  function automatic int sme_rmax(input int smax);
    return smax + (smax * (smax - 1)) / 2;
  endfunction

endpackage

// File: rtl/sme_alu_op_decode.sv
// Purpose: combinational decode of sme_alu_op_t into masked-ALU strobes.
// Latency: 0 cycles (pure combinational). Backpressure: none; strobes are
// forced to 0 whenever en is low.
// Ports: en (strobe enable), op (opcode), strb (one-hot strobes + modifiers).
module sme_alu_op_decode
  import sme_pkg::*;
(
  input  logic          en,
  input  sme_alu_op_t   op,
  output sme_alu_strb_t strb
);

  always_comb begin
    strb = '0;
    if (en) begin
      case (op)
        SME_XOR:    strb.op_xor = 1'b1;
        SME_AND:    strb.op_and = 1'b1;
        SME_OR:     strb.op_or  = 1'b1;
        // Inverted-operand forms reuse the base gadget with rs2 negated.
        SME_ANDN: begin
          strb.op_and    = 1'b1;
          strb.op_notrs2 = 1'b1;
        end
        SME_ORN: begin
          strb.op_or     = 1'b1;
          strb.op_notrs2 = 1'b1;
        end
        SME_XNOR: begin
          strb.op_xor    = 1'b1;
          strb.op_notrs2 = 1'b1;
        end
        SME_SLL: begin
          strb.op_shift = 1'b1;
          strb.op_left  = 1'b1;
        end
        SME_SRL: begin
          strb.op_shift = 1'b1;
          strb.op_right = 1'b1;
        end
        SME_ROL: begin
          strb.op_rotate = 1'b1;
          strb.op_left   = 1'b1;
        end
        SME_ROR: begin
          strb.op_rotate = 1'b1;
          strb.op_right  = 1'b1;
        end
        SME_ADD:    strb.op_add    = 1'b1;
        SME_SUB:    strb.op_sub    = 1'b1;
        SME_MASK:   strb.op_mask   = 1'b1;
        SME_UNMASK: strb.op_unmask = 1'b1;
        SME_REMASK: strb.op_remask = 1'b1;
        default:    strb = '0;
      endcase
    end
  end

endmodule

// File: rtl/sme_alu_seq.sv
// Purpose: sequences one masked ALU op: latch request, collect RNG, run ALU, return result.
// Latency: accept at N -> rsp_valid at N+3, +1 per RNG wait cycle, +1 per ALU wait cycle.
// Backpressure: req_ready only in IDLE; rsp held stable until rsp_valid&&rsp_ready; flush wins.
// Ports: g_clk/g_reset (async high), g_clk_req, flush, req_* (request in),
//   rng_* (randomness handshake), alu_* (to/from masked ALU), rsp_* (response out).
// Optional: define SME_ALU_SEQ_WDOG_EN for an EXEC-cycle watchdog that aborts the
//   op with rsp_err=1 and zeroed result after WDOG_MAX stalled EXEC cycles.
module sme_alu_seq
  import sme_pkg::*;
#(
  parameter  int XLEN     = 32,
  parameter  int SMAX     = 4,
  parameter  int WDOG_MAX = 255,
  localparam int RMAX     = sme_rmax(SMAX)
)(
  input  logic                 g_clk,
  input  logic                 g_reset,
  output logic                 g_clk_req,
  input  logic                 flush,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  sme_alu_op_t          req_op,
  input  logic [4:0]           req_shamt,
  input  logic [SMAX*XLEN-1:0] req_rs1,
  input  logic [SMAX*XLEN-1:0] req_rs2,
  output logic                 rng_req,
  input  logic                 rng_valid,
  input  logic [RMAX*XLEN-1:0] rng_data,
  output logic                 alu_valid,
  input  logic                 alu_ready,
  output logic                 alu_flush,
  output logic                 alu_op_xor,
  output logic                 alu_op_and,
  output logic                 alu_op_or,
  output logic                 alu_op_notrs2,
  output logic                 alu_op_shift,
  output logic                 alu_op_rotate,
  output logic                 alu_op_left,
  output logic                 alu_op_right,
  output logic                 alu_op_add,
  output logic                 alu_op_sub,
  output logic                 alu_op_mask,
  output logic                 alu_op_unmask,
  output logic                 alu_op_remask,
  output logic [4:0]           alu_shamt,
  output logic [SMAX*XLEN-1:0] alu_rs1,
  output logic [SMAX*XLEN-1:0] alu_rs2,
  output logic [RMAX*XLEN-1:0] alu_rng,
  input  logic [SMAX*XLEN-1:0] alu_rd,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [SMAX*XLEN-1:0] rsp_rd,
  output logic                 rsp_err
);

  sme_alu_seq_state_t   state_q, state_d;
  sme_alu_op_t          op_q;
  logic [4:0]           shamt_q;
  logic [SMAX*XLEN-1:0] rs1_q, rs2_q, rd_q;
  logic [RMAX*XLEN-1:0] rng_q;
  sme_alu_strb_t        strb;

  logic accept, rng_take, alu_done, wdog_hit, wdog_abort;

  // Next-state and handshake outputs; flush overrides every transition.
  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    rng_req    = 1'b0;
    alu_valid  = 1'b0;
    alu_flush  = 1'b0;
    rsp_valid  = 1'b0;
    accept     = 1'b0;
    rng_take   = 1'b0;
    alu_done   = 1'b0;
    wdog_abort = 1'b0;
    case (state_q)
      SEQ_IDLE: begin
        req_ready = !flush;
        if (!flush && req_valid) begin
          accept  = 1'b1;
          state_d = SEQ_RNG;
        end
      end
      SEQ_RNG: begin
        rng_req = 1'b1;
        if (flush) begin
          state_d = SEQ_IDLE;
        end else if (rng_valid) begin
          rng_take = 1'b1;
          state_d  = SEQ_EXEC;
        end
      end
      SEQ_EXEC: begin
        alu_valid = 1'b1;
        if (flush) begin
          alu_flush = 1'b1;
          state_d   = SEQ_IDLE;
        end else if (alu_ready) begin
          alu_done = 1'b1;
          state_d  = SEQ_RESP;
        end else if (wdog_hit) begin
          // A result arriving on the limit cycle still wins over the abort.
          alu_flush  = 1'b1;
          wdog_abort = 1'b1;
          state_d    = SEQ_RESP;
        end
      end
      SEQ_RESP: begin
        rsp_valid = 1'b1;
        if (flush || rsp_ready) begin
          state_d = SEQ_IDLE;
        end
      end
      default: state_d = SEQ_IDLE;
    endcase
  end

  // Operand, randomness and result capture. Everything clears on reset so no
  // stale share or mask survives into the next operation's register file.
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      state_q <= SEQ_IDLE;
      op_q    <= SME_XOR;
      shamt_q <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rng_q   <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q    <= req_op;
        shamt_q <= req_shamt;
        rs1_q   <= req_rs1;
        rs2_q   <= req_rs2;
      end
      if (rng_take) begin
        rng_q <= rng_data;
      end
      if (alu_done) begin
        rd_q <= alu_rd;
      end else if (wdog_abort) begin
        rd_q <= '0;
      end
    end
  end

`ifdef SME_ALU_SEQ_WDOG_EN
  localparam logic [7:0] WDOG_LIM = 8'(WDOG_MAX);

  logic [7:0] wdog_cnt;
  logic       err_q;

  assign wdog_hit = (wdog_cnt == WDOG_LIM);

  // Counter restarts on each EXEC entry and counts stalled EXEC cycles.
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      wdog_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (rng_take) begin
        wdog_cnt <= '0;
      end else if (state_q == SEQ_EXEC && !alu_ready) begin
        wdog_cnt <= wdog_cnt + 8'd1;
      end
      if (wdog_abort) begin
        err_q <= 1'b1;
      end else if (state_q == SEQ_RESP && (rsp_ready || flush)) begin
        err_q <= 1'b0;
      end
    end
  end

  assign rsp_err = err_q;
`else
  assign wdog_hit = 1'b0;
  assign rsp_err  = 1'b0;
`endif

  sme_alu_op_decode u_decode (
    .en   (state_q == SEQ_EXEC),
    .op   (op_q),
    .strb (strb)
  );

  assign alu_op_xor    = strb.op_xor;
  assign alu_op_and    = strb.op_and;
  assign alu_op_or     = strb.op_or;
  assign alu_op_notrs2 = strb.op_notrs2;
  assign alu_op_shift  = strb.op_shift;
  assign alu_op_rotate = strb.op_rotate;
  assign alu_op_left   = strb.op_left;
  assign alu_op_right  = strb.op_right;
  assign alu_op_add    = strb.op_add;
  assign alu_op_sub    = strb.op_sub;
  assign alu_op_mask   = strb.op_mask;
  assign alu_op_unmask = strb.op_unmask;
  assign alu_op_remask = strb.op_remask;

  assign alu_shamt = shamt_q;
  assign alu_rs1   = rs1_q;
  assign alu_rs2   = rs2_q;
  assign alu_rng   = rng_q;
  assign rsp_rd    = rd_q;

  assign g_clk_req = (state_q != SEQ_IDLE) || req_valid;

endmodule

// File: tb/tb_sme_alu_seq.sv
// Directed bench for sme_alu_seq: per-opcode vector table plus hand sequences
// for flush, stalls, async reset and (when enabled) the EXEC watchdog.
module tb_sme_alu_seq;
  import sme_pkg::*;

  localparam int XLEN = 32;
  localparam int SMAX = 4;
  localparam int RMAX = 10;
  localparam int SW   = SMAX * XLEN;
  localparam int RW   = RMAX * XLEN;

  localparam logic [12:0] S_XOR = 13'h1000, S_AND = 13'h0800, S_OR  = 13'h0400,
                          S_NOT = 13'h0200, S_SHF = 13'h0100, S_ROT = 13'h0080,
                          S_LFT = 13'h0040, S_RGT = 13'h0020, S_ADD = 13'h0010,
                          S_SUB = 13'h0008, S_MSK = 13'h0004, S_UNM = 13'h0002,
                          S_REM = 13'h0001;

  logic g_clk = 1'b0, g_reset = 1'b1, g_clk_req, flush = 1'b0;
  logic req_valid = 1'b0, req_ready;
  sme_alu_op_t req_op = SME_XOR;
  logic [4:0] req_shamt = '0, alu_shamt;
  logic [SW-1:0] req_rs1 = '0, req_rs2 = '0, alu_rs1, alu_rs2, alu_rd = '0, rsp_rd;
  logic rng_req, rng_valid = 1'b0;
  logic [RW-1:0] rng_data = '0, alu_rng;
  logic alu_valid, alu_ready = 1'b0, alu_flush;
  logic alu_op_xor, alu_op_and, alu_op_or, alu_op_notrs2, alu_op_shift, alu_op_rotate;
  logic alu_op_left, alu_op_right, alu_op_add, alu_op_sub, alu_op_mask, alu_op_unmask;
  logic alu_op_remask;
  logic rsp_valid, rsp_ready = 1'b0, rsp_err;

  sme_alu_seq #(.XLEN(XLEN), .SMAX(SMAX), .WDOG_MAX(255)) dut (
    .g_clk(g_clk), .g_reset(g_reset), .g_clk_req(g_clk_req), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_shamt(req_shamt), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .rng_req(rng_req), .rng_valid(rng_valid), .rng_data(rng_data),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_flush(alu_flush),
    .alu_op_xor(alu_op_xor), .alu_op_and(alu_op_and), .alu_op_or(alu_op_or),
    .alu_op_notrs2(alu_op_notrs2), .alu_op_shift(alu_op_shift),
    .alu_op_rotate(alu_op_rotate), .alu_op_left(alu_op_left),
    .alu_op_right(alu_op_right), .alu_op_add(alu_op_add), .alu_op_sub(alu_op_sub),
    .alu_op_mask(alu_op_mask), .alu_op_unmask(alu_op_unmask),
    .alu_op_remask(alu_op_remask), .alu_shamt(alu_shamt), .alu_rs1(alu_rs1),
    .alu_rs2(alu_rs2), .alu_rng(alu_rng), .alu_rd(alu_rd), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rd(rsp_rd), .rsp_err(rsp_err)
  );

  always #5 g_clk = ~g_clk;

  int cyc = 0;
  always @(posedge g_clk) cyc++;

  logic [12:0] strb;
  assign strb = {alu_op_xor, alu_op_and, alu_op_or, alu_op_notrs2, alu_op_shift,
                 alu_op_rotate, alu_op_left, alu_op_right, alu_op_add, alu_op_sub,
                 alu_op_mask, alu_op_unmask, alu_op_remask};

  int n_vec = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge g_clk);
    #1;
  endtask

  typedef struct {
    sme_alu_op_t op;
    logic [12:0] strb;
    int          rng_wait;
    int          alu_wait;
    int          rsp_wait;
  } vec_t;

  function automatic logic [SW-1:0] mk_rs1(input int i);
    logic [SW-1:0] v;
    for (int k = 0; k < SMAX; k++) v[k*XLEN +: XLEN] = 32'(i * 16 + k + 1);
    return v;
  endfunction

  function automatic logic [SW-1:0] mk_rs2(input int i);
    logic [SW-1:0] v;
    for (int k = 0; k < SMAX; k++) v[k*XLEN +: XLEN] = (k == SMAX - 1) ? 32'(8 + i) : 32'(i);
    return v;
  endfunction

  function automatic logic [RW-1:0] mk_rng(input int i);
    logic [RW-1:0] v;
    for (int j = 0; j < RMAX; j++) v[j*XLEN +: XLEN] = 32'hA000_0000 + 32'(i * 256 + j);
    return v;
  endfunction

  function automatic logic [SW-1:0] mk_rd(input int i);
    logic [SW-1:0] v;
    for (int k = 0; k < SMAX; k++) v[k*XLEN +: XLEN] = 32'hD000_0000 + 32'(i * 16 + k);
    return v;
  endfunction

  task automatic do_accept(input sme_alu_op_t op, input int i);
    req_op    = op;
    req_shamt = 5'(i + 1);
    req_rs1   = mk_rs1(i);
    req_rs2   = mk_rs2(i);
    req_valid = 1'b1;
    #1;
    chk("req_ready idle", req_ready, 1'b1);
    tick();
    req_valid = 1'b0;
    req_rs1   = ~mk_rs1(i);
    req_rs2   = ~mk_rs2(i);
  endtask

  task automatic give_rng(input int i);
    rng_valid = 1'b1;
    rng_data  = mk_rng(i);
    #1;
    tick();
    rng_valid = 1'b0;
    rng_data  = ~mk_rng(i);
  endtask

  task automatic exec_checks(input int i, input logic [12:0] exp_strb);
    chk("alu_valid exec", alu_valid, 1'b1);
    chk("strobes exec", strb, exp_strb);
    chk("alu_rs1 held", alu_rs1, mk_rs1(i));
    chk("alu_rs2 held", alu_rs2, mk_rs2(i));
    chk("alu_rng held", alu_rng, mk_rng(i));
    chk("alu_shamt held", alu_shamt, 5'(i + 1));
    chk("alu_flush exec", alu_flush, 1'b0);
  endtask

  task automatic run_vec(input int i, input vec_t v);
    int n0, k;
    n0 = cyc;
    do_accept(v.op, i);
    for (int d = 0; d < v.rng_wait; d++) begin
      #1;
      chk("rng_req wait", rng_req, 1'b1);
      chk("alu_valid rng", alu_valid, 1'b0);
      chk("strobes rng", strb, 13'h0);
      chk("g_clk_req busy", g_clk_req, 1'b1);
      tick();
    end
    give_rng(i);
    k = 0;
    while (!alu_valid && k < 20) begin
      tick();
      k++;
    end
    chk("alu_valid latency", 32'(cyc - n0), 32'(2 + v.rng_wait));
    for (int w = 0; w < v.alu_wait; w++) begin
      #1;
      exec_checks(i, v.strb);
      tick();
    end
    alu_ready = 1'b1;
    alu_rd    = mk_rd(i);
    #1;
    exec_checks(i, v.strb);
    tick();
    alu_ready = 1'b0;
    alu_rd    = ~mk_rd(i);
    k = 0;
    while (!rsp_valid && k < 20) begin
      tick();
      k++;
    end
    chk("rsp_valid latency", 32'(cyc - n0), 32'(3 + v.rng_wait + v.alu_wait));
    for (int s = 0; s < v.rsp_wait; s++) begin
      #1;
      chk("rsp_valid stall", rsp_valid, 1'b1);
      chk("rsp_rd stall", rsp_rd, mk_rd(i));
      chk("req_ready busy", req_ready, 1'b0);
      chk("strobes resp", strb, 13'h0);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    chk("rsp_rd fire", rsp_rd, mk_rd(i));
    chk("rsp_err normal", rsp_err, 1'b0);
    tick();
    rsp_ready = 1'b0;
    #1;
    chk("rsp_valid after fire", rsp_valid, 1'b0);
    chk("req_ready after fire", req_ready, 1'b1);
  endtask

  vec_t vecs[15];

  initial begin
    vecs[0]  = '{SME_XOR,    S_XOR,         0, 0, 0};
    vecs[1]  = '{SME_AND,    S_AND,         0, 1, 0};
    vecs[2]  = '{SME_OR,     S_OR,          1, 0, 0};
    vecs[3]  = '{SME_ANDN,   S_AND | S_NOT, 0, 0, 1};
    vecs[4]  = '{SME_ORN,    S_OR  | S_NOT, 5, 0, 0};
    vecs[5]  = '{SME_XNOR,   S_XOR | S_NOT, 0, 2, 0};
    vecs[6]  = '{SME_SLL,    S_SHF | S_LFT, 0, 0, 0};
    vecs[7]  = '{SME_SRL,    S_SHF | S_RGT, 2, 0, 0};
    vecs[8]  = '{SME_ROL,    S_ROT | S_LFT, 0, 0, 2};
    vecs[9]  = '{SME_ROR,    S_ROT | S_RGT, 0, 1, 0};
    vecs[10] = '{SME_ADD,    S_ADD,         0, 3, 0};
    vecs[11] = '{SME_SUB,    S_SUB,         0, 0, 4};
    vecs[12] = '{SME_MASK,   S_MSK,         1, 1, 1};
    vecs[13] = '{SME_UNMASK, S_UNM,         0, 0, 0};
    vecs[14] = '{SME_REMASK, S_REM,         3, 2, 1};

    // Reset state.
    #2;
    chk("rst req_ready", req_ready, 1'b1);
    chk("rst rng_req", rng_req, 1'b0);
    chk("rst alu_valid", alu_valid, 1'b0);
    chk("rst rsp_valid", rsp_valid, 1'b0);
    chk("rst alu_flush", alu_flush, 1'b0);
    chk("rst strobes", strb, 13'h0);
    chk("rst alu_rs1", alu_rs1, '0);
    chk("rst alu_rng", alu_rng, '0);
    chk("rst rsp_rd", rsp_rd, '0);
    chk("rst rsp_err", rsp_err, 1'b0);
    chk("rst g_clk_req", g_clk_req, 1'b0);
    @(negedge g_clk);
    g_reset = 1'b0;
    tick();

    for (int i = 0; i < 15; i++) run_vec(i, vecs[i]);

    // Flush in IDLE blocks the request.
    flush = 1'b1;
    req_valid = 1'b1;
    #1;
    chk("flush idle req_ready", req_ready, 1'b0);
    chk("g_clk_req on req_valid", g_clk_req, 1'b1);
    tick();
    flush = 1'b0;
    req_valid = 1'b0;
    #1;
    chk("flush idle no accept", rng_req, 1'b0);
    chk("g_clk_req idle", g_clk_req, 1'b0);

    // Flush in the second EXEC cycle.
    do_accept(SME_AND, 20);
    give_rng(20);
    #1;
    chk("exec1 alu_valid", alu_valid, 1'b1);
    tick();
    flush = 1'b1;
    #1;
    chk("flush exec alu_flush", alu_flush, 1'b1);
    tick();
    flush = 1'b0;
    #1;
    chk("post flush alu_valid", alu_valid, 1'b0);
    chk("post flush req_ready", req_ready, 1'b1);
    chk("post flush alu_flush", alu_flush, 1'b0);
    for (int c = 0; c < 3; c++) begin
      chk("post flush no rsp", rsp_valid, 1'b0);
      tick();
    end

    // Flush in RNG with rng_valid: the RNG word must not be latched.
    do_accept(SME_OR, 21);
    rng_valid = 1'b1;
    rng_data  = mk_rng(21);
    flush     = 1'b1;
    #1;
    chk("flush rng rng_req", rng_req, 1'b1);
    tick();
    flush = 1'b0;
    rng_valid = 1'b0;
    #1;
    chk("flush rng idle", rng_req, 1'b0);
    chk("flush rng not latched", alu_rng, mk_rng(20));

    // Flush in RESP drops the response.
    do_accept(SME_ADD, 22);
    give_rng(22);
    alu_ready = 1'b1;
    alu_rd    = mk_rd(22);
    tick();
    alu_ready = 1'b0;
    #1;
    chk("resp before flush", rsp_valid, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    chk("flush resp drops", rsp_valid, 1'b0);
    chk("flush resp req_ready", req_ready, 1'b1);

`ifdef SME_ALU_SEQ_WDOG_EN
    // Watchdog abort after 255 stalled EXEC cycles.
    begin
      int k;
      do_accept(SME_SUB, 23);
      give_rng(23);
      k = 1;
      #1;
      while (!alu_flush && k < 300) begin
        tick();
        #1;
        k++;
      end
      chk("wdog flush cycle", 32'(k), 32'd256);
      tick();
      #1;
      chk("wdog rsp_valid", rsp_valid, 1'b1);
      chk("wdog rsp_err", rsp_err, 1'b1);
      chk("wdog rsp_rd zero", rsp_rd, '0);
      chk("wdog flush pulse", alu_flush, 1'b0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      #1;
      chk("wdog err cleared", rsp_err, 1'b0);
    end
`endif

    // Async reset mid-operation.
    do_accept(SME_XOR, 24);
    give_rng(24);
    #1;
    chk("pre reset exec", alu_valid, 1'b1);
    #1;
    g_reset = 1'b1;
    #1;
    chk("async rst alu_valid", alu_valid, 1'b0);
    chk("async rst req_ready", req_ready, 1'b1);
    chk("async rst alu_rs1", alu_rs1, '0);
    chk("async rst alu_rng", alu_rng, '0);
    tick();
    g_reset = 1'b0;
    tick();
    #1;
    chk("after rst idle", rsp_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
